// File: rtl/orange_frame_scheduler_if.sv
// orange_frame_scheduler_if
// Carries the steering command from the frame scheduler to the motor-control side.
// Uses a valid/ready handshake. The scheduler drives the master modport and the
// consumer drives the slave modport.
interface orange_frame_scheduler_if #(
   parameter int CNT_W = 18
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [2:0]       cmd_dir;
   logic [CNT_W-1:0] cmd_count;

   modport master (
      output cmd_valid,
      output cmd_dir,
      output cmd_count,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_dir,
      input  cmd_count,
      output cmd_ready
   );
endinterface

// File: rtl/orange_frame_scheduler.sv
// orange_frame_scheduler
// Per-frame orange-pixel binning into left/centre/right column zones, a frame-end
// steering decision, and multi-frame confirmation before a command is handed to
// motor control.
// Optional feature macro: ORANGE_CONFIRM_EN. When it is defined, CONFIRM_FRAMES
// identical candidates are needed to issue a command. When it is undefined, any
// single error-free frame confirms.
module orange_frame_scheduler #(
   parameter int H_PIXELS       = 320,
   parameter int V_LINES        = 240,
   parameter int LEFT_EDGE      = 50,
   parameter int RIGHT_EDGE     = 270,
   parameter int DETECT_THRESH  = 19200,
   parameter int MIN_PIXELS     = 64,
   parameter int CONFIRM_FRAMES = 3,
   parameter int CNT_W          = 18
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        vsync,
   input  logic                        href,
   input  logic                        pixel_valid,
   input  logic                        is_orange,
   orange_frame_scheduler_if.master    cmd,
   output logic                        frame_done,
   output logic                        frame_err,
   output logic                        busy
);

   typedef enum logic [2:0] {IDLE, WAIT_FRAME, ACTIVE, EVAL, DECIDE} state_t;

   localparam logic [2:0] DIR_NONE   = 3'b000;
   localparam logic [2:0] DIR_LEFT   = 3'b001;
   localparam logic [2:0] DIR_RIGHT  = 3'b010;
   localparam logic [2:0] DIR_CENTRE = 3'b011;
   localparam logic [2:0] DIR_STOP   = 3'b100;

   localparam logic [CNT_W-1:0] H_LIM   = CNT_W'(H_PIXELS);
   localparam logic [CNT_W-1:0] V_LIM   = CNT_W'(V_LINES);
   localparam logic [CNT_W-1:0] L_EDGE  = CNT_W'(LEFT_EDGE);
   localparam logic [CNT_W-1:0] R_EDGE  = CNT_W'(RIGHT_EDGE);
   localparam logic [CNT_W-1:0] THRESH  = CNT_W'(DETECT_THRESH);
   localparam logic [CNT_W-1:0] MIN_PIX = CNT_W'(MIN_PIXELS);

   // The confirm counter stops climbing at the confirmation depth.
   // Holding there keeps a confirmed change alive while a command is still pending.
   localparam logic [3:0] CONF_MAX = 4'(CONFIRM_FRAMES);
`ifdef ORANGE_CONFIRM_EN
   localparam logic [3:0] CONF_LIM = CONF_MAX;
`else
   localparam logic [3:0] CONF_LIM = 4'd1;
`endif

   state_t           state, state_nxt;
   logic             vsync_q, href_q;
   logic             vsync_rise, vsync_fall, href_fall, pix_q;
   logic [CNT_W-1:0] col_cnt, line_cnt, left_cnt, centre_cnt, right_cnt, total_cnt;
   logic             geom_bad;
   logic [2:0]       cand_c, cand_r, prev_cand, last_dir;
   logic             eval_err, err_r;
   logic [3:0]       conf_cnt, conf_nxt;
   logic             issue;
   logic             cmd_valid_r;
   logic [2:0]       cmd_dir_r;
   logic [CNT_W-1:0] cmd_count_r;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign vsync_rise = vsync & ~vsync_q;
   assign vsync_fall = ~vsync & vsync_q;
   assign href_fall  = ~href & href_q;
   assign pix_q      = pixel_valid & href;

   assign cmd.cmd_valid = cmd_valid_r;
   assign cmd.cmd_dir   = cmd_dir_r;
   assign cmd.cmd_count = cmd_count_r;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state selection and per-state strobes
   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      frame_err  = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE:       if (enable) state_nxt = WAIT_FRAME;
         WAIT_FRAME: begin
            if (!enable)         state_nxt = IDLE;
            else if (vsync_fall) state_nxt = ACTIVE;
         end
         ACTIVE:     if (vsync_rise) state_nxt = EVAL;
         EVAL:       state_nxt = DECIDE;
         DECIDE: begin
            frame_done = 1'b1;
            frame_err  = err_r;
            state_nxt  = WAIT_FRAME;
         end
         default:    state_nxt = IDLE;
      endcase
   end

   // Frame-end candidate: bad geometry first, then stop, then too few pixels, then zone vote
   always_comb begin
      cand_c   = DIR_NONE;
      eval_err = 1'b0;
      if (geom_bad || (line_cnt != V_LIM))
         eval_err = 1'b1;
      else if (total_cnt > THRESH)
         cand_c = DIR_STOP;
      else if (total_cnt < MIN_PIX)
         cand_c = DIR_NONE;
      else if ((left_cnt > right_cnt) && (left_cnt > centre_cnt))
         cand_c = DIR_LEFT;
      else if ((right_cnt > left_cnt) && (right_cnt > centre_cnt))
         cand_c = DIR_RIGHT;
      else
         cand_c = DIR_CENTRE;
   end

   // Confirmation count for this frame and the decision to issue a command
   always_comb begin
      conf_nxt = 4'd1;
      if (err_r)
         conf_nxt = 4'd0;
      else if (cand_r == prev_cand)
         conf_nxt = (conf_cnt >= CONF_MAX) ? conf_cnt : conf_cnt + 4'd1;
      issue = (conf_nxt != 4'd0) && (conf_nxt >= CONF_LIM) &&
              (cand_r != last_dir) && !cmd_valid_r;
   end

   // Edge history, pixel counting, and the command holding register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         col_cnt     <= '0;
         line_cnt    <= '0;
         left_cnt    <= '0;
         centre_cnt  <= '0;
         right_cnt   <= '0;
         total_cnt   <= '0;
         geom_bad    <= 1'b0;
         cand_r      <= DIR_NONE;
         err_r       <= 1'b0;
         prev_cand   <= DIR_NONE;
         last_dir    <= DIR_NONE;
         conf_cnt    <= 4'd0;
         cmd_valid_r <= 1'b0;
         cmd_dir_r   <= DIR_NONE;
         cmd_count_r <= '0;
      end else begin
         vsync_q <= vsync;
         href_q  <= href;

         if (state == WAIT_FRAME && vsync_fall) begin
            col_cnt    <= '0;
            line_cnt   <= '0;
            left_cnt   <= '0;
            centre_cnt <= '0;
            right_cnt  <= '0;
            total_cnt  <= '0;
            geom_bad   <= 1'b0;
         end else if (state == ACTIVE) begin
            // A qualified pixel needs href high and href_fall needs href low,
            // so the two branches never fire together.
            if (pix_q) begin
               col_cnt <= sat_inc(col_cnt);
               if (col_cnt >= H_LIM)
                  geom_bad <= 1'b1;
               else if (is_orange && (line_cnt < V_LIM)) begin
                  total_cnt <= sat_inc(total_cnt);
                  if (col_cnt < L_EDGE)      left_cnt   <= sat_inc(left_cnt);
                  else if (col_cnt < R_EDGE) centre_cnt <= sat_inc(centre_cnt);
                  else                       right_cnt  <= sat_inc(right_cnt);
               end
            end
            if (href_fall) begin
               col_cnt  <= '0;
               line_cnt <= sat_inc(line_cnt);
               if (col_cnt < H_LIM) geom_bad <= 1'b1;
            end
         end

         if (state == EVAL) begin
            cand_r <= cand_c;
            err_r  <= eval_err;
         end

         if (cmd_valid_r && cmd.cmd_ready)
            cmd_valid_r <= 1'b0;

         if (state == DECIDE) begin
            conf_cnt  <= conf_nxt;
            prev_cand <= cand_r;
            if (issue) begin
               cmd_valid_r <= 1'b1;
               cmd_dir_r   <= cand_r;
               cmd_count_r <= total_cnt;
               last_dir    <= cand_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_orange_frame_scheduler.sv
// tb_orange_frame_scheduler
// Directed frames on an 8x4 geometry for orange_frame_scheduler. The expected
// confirmation depth follows ORANGE_CONFIRM_EN: 3 frames when it is defined,
// 1 frame when it is not.
module tb_orange_frame_scheduler;
   localparam int CNT_W = 18;
`ifdef ORANGE_CONFIRM_EN
   localparam int CONF = 3;
`else
   localparam int CONF = 1;
`endif

   logic clk = 1'b0;
   logic rst_n, enable, vsync, href, pixel_valid, is_orange;
   logic frame_done, frame_err, busy;

   int checks   = 0;
   int failures = 0;

   logic [31:0] f_done, f_err, f_vld, f_dir, f_cnt, f_vld_nxt;

   orange_frame_scheduler_if #(.CNT_W(CNT_W)) cmd_if ();

   orange_frame_scheduler #(
      .H_PIXELS       (8),
      .V_LINES        (4),
      .LEFT_EDGE      (2),
      .RIGHT_EDGE     (6),
      .DETECT_THRESH  (16),
      .MIN_PIXELS     (2),
      .CONFIRM_FRAMES (3),
      .CNT_W          (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .vsync       (vsync),
      .href        (href),
      .pixel_valid (pixel_valid),
      .is_orange   (is_orange),
      .cmd         (cmd_if),
      .frame_done  (frame_done),
      .frame_err   (frame_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // One frame: 4 lines of 8 pixels (one line shortened to 6 when short_ln matches),
   // with is_orange taken from mask bit [column]. Samples frame_done/frame_err at t+2
   // and the command at t+3 and t+4, where t is the first vsync-high cycle.
   task automatic run_frame(input logic [7:0] mask, input int short_ln);
      vsync = 1'b0;
      tick;
      tick;
      for (int ln = 0; ln < 4; ln++) begin
         for (int c = 0; c < ((ln == short_ln) ? 6 : 8); c++) begin
            href        = 1'b1;
            pixel_valid = 1'b1;
            is_orange   = mask[c];
            tick;
         end
         href        = 1'b0;
         pixel_valid = 1'b0;
         is_orange   = 1'b0;
         tick;
         tick;
      end
      vsync = 1'b1;
      tick;
      tick;
      f_done = 32'(frame_done);
      f_err  = 32'(frame_err);
      tick;
      f_vld = 32'(cmd_if.cmd_valid);
      f_dir = 32'(cmd_if.cmd_dir);
      f_cnt = 32'(cmd_if.cmd_count);
      tick;
      f_vld_nxt = 32'(cmd_if.cmd_valid);
      tick;
   endtask

   initial begin
      rst_n            = 1'b0;
      enable           = 1'b0;
      vsync            = 1'b1;
      href             = 1'b0;
      pixel_valid      = 1'b0;
      is_orange        = 1'b0;
      cmd_if.cmd_ready = 1'b1;
      repeat (3) tick;
      check("rst_valid", 32'(cmd_if.cmd_valid), 0);
      check("rst_dir",   32'(cmd_if.cmd_dir),   0);
      check("rst_count", 32'(cmd_if.cmd_count), 0);
      check("rst_done",  32'(frame_done),       0);
      check("rst_busy",  32'(busy),             0);

      rst_n  = 1'b1;
      enable = 1'b1;
      repeat (3) tick;
      check("en_busy", 32'(busy), 1);

      // Right zone only: columns 6-7 on every line, total 8
      for (int k = 1; k <= CONF; k++) begin
         run_frame(8'hC0, -1);
         check("right_done", f_done, 1);
         check("right_err",  f_err,  0);
         check("right_vld",  f_vld,  32'(k == CONF));
      end
      check("right_dir",      f_dir,     2);
      check("right_cnt",      f_cnt,     8);
      check("right_vld_once", f_vld_nxt, 0);

      // Every pixel orange: 32 > 16 gives stop
      for (int k = 1; k <= CONF; k++) begin
         run_frame(8'hFF, -1);
         check("stop_vld", f_vld, 32'(k == CONF));
      end
      check("stop_dir", f_dir, 4);
      check("stop_cnt", f_cnt, 32);
      run_frame(8'hFF, -1);
      check("stop_repeat_vld", f_vld, 0);

      // Left 4 / right 4 / centre 0: side tie resolves to centre
      for (int k = 1; k <= CONF; k++) begin
         run_frame(8'h81, -1);
         check("tie_vld", f_vld, 32'(k == CONF));
      end
      check("tie_dir", f_dir, 3);
      check("tie_cnt", f_cnt, 8);

      // Partial left run, then a short line 2 resets confirmation
      for (int k = 1; k < CONF; k++) begin
         run_frame(8'h03, -1);
         check("pre_err_vld", f_vld, 0);
      end
      run_frame(8'hC0, 2);
      check("geom_done", f_done, 1);
      check("geom_err",  f_err,  1);
      check("geom_vld",  f_vld,  0);
      for (int k = 1; k <= CONF; k++) begin
         run_frame(8'h03, -1);
         check("post_err_vld", f_vld, 32'(k == CONF));
      end
      check("post_err_dir", f_dir, 1);
      check("post_err_cnt", f_cnt, 8);

      // Centre command held with ready low while left frames confirm
      cmd_if.cmd_ready = 1'b0;
      for (int k = 1; k <= CONF; k++) begin
         run_frame(8'h3C, -1);
         check("centre_vld", f_vld, 32'(k == CONF));
      end
      check("centre_dir", f_dir, 3);
      check("centre_cnt", f_cnt, 16);
      for (int k = 1; k <= CONF; k++) begin
         run_frame(8'h03, -1);
         check("hold_vld", f_vld, 1);
         check("hold_dir", f_dir, 3);
      end
      cmd_if.cmd_ready = 1'b1;
      tick;
      tick;
      check("accept_vld", 32'(cmd_if.cmd_valid), 0);
      run_frame(8'h03, -1);
      check("deferred_vld", f_vld, 1);
      check("deferred_dir", f_dir, 1);

      // Pending right command, then reset in the middle of an active line
      cmd_if.cmd_ready = 1'b0;
      for (int k = 1; k <= CONF; k++) begin
         run_frame(8'hC0, -1);
         check("pend_vld", f_vld, 32'(k == CONF));
      end
      vsync = 1'b0;
      tick;
      tick;
      href        = 1'b1;
      pixel_valid = 1'b1;
      is_orange   = 1'b1;
      repeat (3) tick;
      check("mid_busy", 32'(busy), 1);
      rst_n = 1'b0;
      tick;
      check("mrst_valid", 32'(cmd_if.cmd_valid), 0);
      check("mrst_dir",   32'(cmd_if.cmd_dir),   0);
      check("mrst_count", 32'(cmd_if.cmd_count), 0);
      check("mrst_busy",  32'(busy),             0);
      check("mrst_done",  32'(frame_done),       0);
      rst_n            = 1'b1;
      href             = 1'b0;
      pixel_valid      = 1'b0;
      is_orange        = 1'b0;
      vsync            = 1'b1;
      cmd_if.cmd_ready = 1'b1;
      repeat (3) tick;
      for (int k = 1; k <= CONF; k++) begin
         run_frame(8'hC0, -1);
         check("after_rst_vld", f_vld, 32'(k == CONF));
      end
      check("after_rst_dir", f_dir, 2);
      check("after_rst_cnt", f_cnt, 8);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
